// File: rtl/ahb_slave_if_if.sv
// AHB-side bus bundle between the AHB master/APB controller and ahb_slave_if.
// The slave modport is the bridge front end; the master modport drives the stimulus side.
interface ahb_slave_if_if;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        hready_out;
    logic        valid;
    logic [31:0] haddr_1;
    logic [31:0] haddr_2;
    logic [31:0] hwdata_1;
    logic [31:0] hwdata_2;
    logic        hwrite_reg;
    logic [2:0]  tempselx;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, hready_out,
        output valid, haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg,
        output tempselx, hreadyout, hresp, hrdata
    );

    modport master (
        output hwrite, hreadyin, htrans, haddr, hwdata, prdata, hready_out,
        input  valid, haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg,
        input  tempselx, hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: transfer qualification, address decode,
// two-deep address/data pipeline and the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if #(
    parameter logic [31:0] BASE0 = 32'h8000_0000,
    parameter logic [31:0] BASE1 = 32'h8400_0000,
    parameter logic [31:0] BASE2 = 32'h8800_0000
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_if_if.slave  bus
);
    localparam logic [31:0] WIN_MASK = 32'hFC00_0000;

    typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} err_state_e;

    err_state_e  err_state_q, err_state_d;
    logic [31:0] haddr_1_q, haddr_1_d;
    logic [31:0] haddr_2_q, haddr_2_d;
    logic [31:0] hwdata_1_q, hwdata_1_d;
    logic [31:0] hwdata_2_q, hwdata_2_d;
    logic        hwrite_reg_q, hwrite_reg_d;
    logic [2:0]  tempselx;
    logic        active;
    logic        hreadyout;
    logic [1:0]  hresp;

    // Windows are 64 MiB aligned, so matching the top six address bits is enough.
    always_comb begin
        tempselx = 3'b000;
        if ((bus.haddr & WIN_MASK) == BASE0)      tempselx = 3'b001;
        else if ((bus.haddr & WIN_MASK) == BASE1) tempselx = 3'b010;
        else if ((bus.haddr & WIN_MASK) == BASE2) tempselx = 3'b100;
    end

    assign active = bus.hreadyin & bus.htrans[1];

    always_comb begin
        haddr_1_d    = haddr_1_q;
        haddr_2_d    = haddr_2_q;
        hwdata_1_d   = hwdata_1_q;
        hwdata_2_d   = hwdata_2_q;
        hwrite_reg_d = hwrite_reg_q;
        if (bus.hreadyin) begin
            haddr_1_d    = bus.haddr;
            haddr_2_d    = haddr_1_q;
            hwdata_1_d   = bus.hwdata;
            hwdata_2_d   = hwdata_1_q;
            hwrite_reg_d = bus.hwrite;
        end
    end

    // ERR2 ignores whatever transfer is presented, so a stale unmapped address cannot re-arm.
    always_comb begin
        err_state_d = err_state_q;
        hresp       = 2'b00;
        hreadyout   = bus.hready_out;
        unique case (err_state_q)
            ST_OK: begin
                if (active && tempselx == 3'b000) err_state_d = ST_ERR1;
            end
            ST_ERR1: begin
                hresp       = 2'b01;
                hreadyout   = 1'b0;
                err_state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp       = 2'b01;
                hreadyout   = 1'b1;
                err_state_d = ST_OK;
            end
            default: err_state_d = ST_OK;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_state_q  <= ST_OK;
            haddr_1_q    <= '0;
            haddr_2_q    <= '0;
            hwdata_1_q   <= '0;
            hwdata_2_q   <= '0;
            hwrite_reg_q <= 1'b0;
        end else begin
            err_state_q  <= err_state_d;
            haddr_1_q    <= haddr_1_d;
            haddr_2_q    <= haddr_2_d;
            hwdata_1_q   <= hwdata_1_d;
            hwdata_2_q   <= hwdata_2_d;
            hwrite_reg_q <= hwrite_reg_d;
        end
    end

    assign bus.valid      = active && (tempselx != 3'b000) && (err_state_q == ST_OK);
    assign bus.tempselx   = tempselx;
    assign bus.haddr_1    = haddr_1_q;
    assign bus.haddr_2    = haddr_2_q;
    assign bus.hwdata_1   = hwdata_1_q;
    assign bus.hwdata_2   = hwdata_2_q;
    assign bus.hwrite_reg = hwrite_reg_q;
    assign bus.hreadyout  = hreadyout;
    assign bus.hresp      = hresp;
    assign bus.hrdata     = bus.prdata;
endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the bridge front end.
module tb_ahb_slave_if;
    localparam logic [31:0] B0  = 32'h8000_0000;
    localparam logic [31:0] B1  = 32'h8400_0000;
    localparam logic [31:0] B2  = 32'h8800_0000;
    localparam logic [31:0] WIN = 32'h0400_0000;

    logic hclk = 1'b0;
    logic hreset;
    int   errors = 0;
    int   checks = 0;

    ahb_slave_if_if bus();

    ahb_slave_if #(.BASE0(B0), .BASE1(B1), .BASE2(B2)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    // Model state: pipeline contents and remaining ERROR cycles (2 = first, 1 = second).
    logic [31:0] m_h1, m_h2, m_w1, m_w2;
    logic        m_wr;
    int          m_err;
    bit          started = 0;

    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        if (a - B0 < WIN) return 3'b001;
        if (a - B1 < WIN) return 3'b010;
        if (a - B2 < WIN) return 3'b100;
        return 3'b000;
    endfunction

    always @(posedge hclk) begin
        if (hreset) begin
            m_h1 = 0; m_h2 = 0; m_w1 = 0; m_w2 = 0; m_wr = 0; m_err = 0;
            started = 1;
        end else begin
            if (bus.hreadyin) begin
                m_h2 = m_h1; m_h1 = bus.haddr;
                m_w2 = m_w1; m_w1 = bus.hwdata;
                m_wr = bus.hwrite;
            end
            if (m_err > 0) m_err = m_err - 1;
            else if (bus.hreadyin && bus.htrans >= 2 && exp_sel(bus.haddr) == 0) m_err = 2;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge hclk) begin
        if (started) begin
            logic act;
            act = bus.hreadyin && bus.htrans >= 2;
            chk("m_sel",   {29'd0, bus.tempselx}, {29'd0, exp_sel(bus.haddr)});
            chk("m_valid", {31'd0, bus.valid},
                {31'd0, act && exp_sel(bus.haddr) != 0 && m_err == 0});
            chk("m_h1", bus.haddr_1, m_h1);
            chk("m_h2", bus.haddr_2, m_h2);
            chk("m_w1", bus.hwdata_1, m_w1);
            chk("m_w2", bus.hwdata_2, m_w2);
            chk("m_wr", {31'd0, bus.hwrite_reg}, {31'd0, m_wr});
            chk("m_hresp", {30'd0, bus.hresp}, (m_err > 0) ? 32'd1 : 32'd0);
            chk("m_hreadyout", {31'd0, bus.hreadyout},
                (m_err == 2) ? 32'd0 : (m_err == 1) ? 32'd1 : {31'd0, bus.hready_out});
            chk("m_hrdata", bus.hrdata, bus.prdata);
        end
    end

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [31:0] d);
        bus.haddr = a; bus.htrans = t; bus.hwrite = w; bus.hwdata = d;
    endtask

    initial begin
        hreset = 1'b1;
        bus.hreadyin = 1'b1; bus.hready_out = 1'b1; bus.prdata = 32'h1234_5678;
        drive(32'h8000_0010, 2'b10, 1'b0, 32'h0);
        step(); step();
        hreset = 1'b0;
        @(negedge hclk);
        chk("rst_h1", bus.haddr_1, 32'h0);
        chk("rst_h2", bus.haddr_2, 32'h0);
        chk("rst_w1", bus.hwdata_1, 32'h0);
        chk("rst_wr", {31'd0, bus.hwrite_reg}, 32'd0);
        chk("rst_hresp", {30'd0, bus.hresp}, 32'd0);
        bus.htrans = 2'b00;
        #1;
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        step();

        // Mapped NONSEQ write with data on the following cycle.
        drive(32'h8400_0004, 2'b10, 1'b1, 32'h0);
        @(negedge hclk);
        chk("wr_valid", {31'd0, bus.valid}, 32'd1);
        chk("wr_sel", {29'd0, bus.tempselx}, 32'd2);
        step();
        drive(32'h8000_0000, 2'b00, 1'b1, 32'hDEAD_BEEF);
        @(negedge hclk);
        chk("wr_h1", bus.haddr_1, 32'h8400_0004);
        chk("wr_hwrite", {31'd0, bus.hwrite_reg}, 32'd1);
        step();
        @(negedge hclk);
        chk("wr_h2", bus.haddr_2, 32'h8400_0004);
        chk("wr_w1", bus.hwdata_1, 32'hDEAD_BEEF);
        step();

        // Unmapped NONSEQ -> two-cycle ERROR.
        drive(32'h9000_0000, 2'b10, 1'b0, 32'h0);
        @(negedge hclk);
        chk("un_valid", {31'd0, bus.valid}, 32'd0);
        chk("un_hresp0", {30'd0, bus.hresp}, 32'd0);
        step();
        bus.htrans = 2'b00;
        @(negedge hclk);
        chk("err1_hresp", {30'd0, bus.hresp}, 32'd1);
        chk("err1_rdy", {31'd0, bus.hreadyout}, 32'd0);
        step();
        @(negedge hclk);
        chk("err2_hresp", {30'd0, bus.hresp}, 32'd1);
        chk("err2_rdy", {31'd0, bus.hreadyout}, 32'd1);
        step();
        @(negedge hclk);
        chk("ok_hresp", {30'd0, bus.hresp}, 32'd0);

        // BUSY then IDLE on a mapped address.
        drive(32'h8800_0000, 2'b01, 1'b0, 32'h0);
        @(negedge hclk);
        chk("busy_valid", {31'd0, bus.valid}, 32'd0);
        chk("busy_sel", {29'd0, bus.tempselx}, 32'd4);
        step();
        bus.htrans = 2'b00;
        @(negedge hclk);
        chk("idle_hresp", {30'd0, bus.hresp}, 32'd0);
        step();

        // Freeze the pipeline with hreadyin low.
        drive(32'h8000_0100, 2'b00, 1'b0, 32'h0); step();
        drive(32'h8000_0200, 2'b00, 1'b0, 32'h0); step();
        bus.hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h8400_1000 + i * 4, 2'b10, 1'b0, 32'h0);
            @(negedge hclk);
            chk("frz_h1", bus.haddr_1, 32'h8000_0200);
            chk("frz_h2", bus.haddr_2, 32'h8000_0100);
            chk("frz_valid", {31'd0, bus.valid}, 32'd0);
            step();
        end
        bus.hreadyin = 1'b1;
        bus.htrans = 2'b00;

        bus.hready_out = 1'b0;
        @(negedge hclk);
        chk("ctl_rdy", {31'd0, bus.hreadyout}, 32'd0);
        step();
        bus.hready_out = 1'b1;

        // Reset during ERR1 clears the error at once.
        drive(32'h0000_0040, 2'b10, 1'b0, 32'h0);
        step();
        bus.htrans = 2'b00;
        hreset = 1'b1;
        @(negedge hclk);
        chk("rerr_hresp1", {30'd0, bus.hresp}, 32'd1);
        step();
        hreset = 1'b0;
        @(negedge hclk);
        chk("rerr_hresp0", {30'd0, bus.hresp}, 32'd0);
        chk("rerr_rdy", {31'd0, bus.hreadyout}, 32'd1);
        step();

        // Randomized traffic, checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0: a = B0 + ($urandom & 32'h03FF_FFFF);
                1: a = B1 + ($urandom & 32'h03FF_FFFF);
                2: a = B2 + ($urandom & 32'h03FF_FFFF);
                3: a = B0 + WIN - 1;
                4: a = B2 + WIN;
                5: a = B0 - 1;
                default: a = $urandom;
            endcase
            drive(a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom);
            bus.hreadyin   = ($urandom_range(0, 4) != 0);
            bus.hready_out = ($urandom_range(0, 3) != 0);
            bus.prdata     = $urandom;
            hreset         = ($urandom_range(0, 99) == 0);
            step();
        end
        hreset = 1'b0;
        @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
